// File: rtl/llprefetch_pkg.sv
// Shared page-manager definitions: default page-number width and a
// constant-foldable ceil(log2) helper used to size counters and pointers.
package llprefetch_pkg;

  localparam int LPSZ_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/llprefetch_if.sv
// Prefetch channel bundle: page request/grant, manager page delivery and the
// packet-writer side. master = prefetcher, slave = manager/writer environment.
interface llprefetch_if
  import llprefetch_pkg::*;
#(
  parameter int lpsz  = LPSZ_DEF,
  parameter int depth = 4
);

  localparam int lw = clog2(depth) + 1;

  logic            pgreq;
  logic            pgack;
  logic            lprq_srdy;
  logic            lprq_drdy;
  logic [lpsz-1:0] lprq_page;
  logic            p_srdy;
  logic            p_drdy;
  logic [lpsz-1:0] p_page;
  logic [lw-1:0]   level;

  modport master (
    output pgreq, lprq_drdy, p_srdy, p_page, level,
    input  pgack, lprq_srdy, lprq_page, p_drdy
  );

  modport slave (
    input  pgreq, lprq_drdy, p_srdy, p_page, level,
    output pgack, lprq_srdy, lprq_page, p_drdy
  );

endinterface

// File: rtl/llpf_fifo.sv
// Local free-page FIFO: register array with power-of-two wrapping pointers
// and an occupancy count. Writes when full and reads when empty are dropped.
module llpf_fifo
  import llprefetch_pkg::*;
#(
  parameter int width = LPSZ_DEF,
  parameter int depth = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [width-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [width-1:0]      rd_data_o,
  output logic [clog2(depth):0] count_o,
  output logic                  full_o
);

  localparam int aw = clog2(depth);
  localparam logic [aw:0] DEPTH_C = (aw + 1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [aw-1:0]    wr_ptr_q;
  logic [aw-1:0]    rd_ptr_q;
  logic [aw:0]      count_q;
  logic [aw:0]      count_d;
  logic             wr_s;
  logic             rd_s;

  assign wr_s      = wr_en_i && (count_q != DEPTH_C);
  assign rd_s      = rd_en_i && (count_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == DEPTH_C);

  always_comb begin
    count_d = count_q;
    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (wr_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_s) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/llprefetch.sv
// Free-page prefetcher: keeps buffered + outstanding pages at the buffer depth
// by requesting pages from the link-list manager and queuing them locally.
module llprefetch
  import llprefetch_pkg::*;
#(
  parameter int lpsz  = LPSZ_DEF,
  parameter int depth = 4
) (
  input  logic          clk,
  input  logic          reset,
  llprefetch_if.master  pf
);

  localparam int lw = clog2(depth) + 1;
  localparam logic [lw:0] DEPTH_C = (lw + 1)'(depth);

  logic [lw-1:0]   outstanding_q;
  logic [lw-1:0]   outstanding_d;
  logic            rst_q;
  logic [lw-1:0]   count_s;
  logic            full_s;
  logic [lpsz-1:0] head_s;
  logic [lw:0]     credit_s;
  logic            grant_s;
  logic            recv_s;
  logic            rd_s;

  // Outputs derive only from registers; rst_q holds pgreq low through reset.
  assign credit_s     = {1'b0, count_s} + {1'b0, outstanding_q};
  assign pf.pgreq     = !rst_q && (credit_s < DEPTH_C);
  assign pf.lprq_drdy = (outstanding_q != '0) && !full_s;
  assign pf.p_srdy    = (count_s != '0);
  assign pf.p_page    = pf.p_srdy ? head_s : '0;
  assign pf.level     = count_s;

  assign grant_s = pf.pgreq && pf.pgack;
  assign recv_s  = pf.lprq_srdy && pf.lprq_drdy;
  assign rd_s    = pf.p_srdy && pf.p_drdy;

  always_comb begin
    outstanding_d = outstanding_q;
    if (grant_s && !recv_s) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (recv_s && !grant_s) begin
      outstanding_d = outstanding_q - 1'b1;
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_q         <= 1'b1;
      outstanding_q <= '0;
    end else begin
      rst_q         <= 1'b0;
      outstanding_q <= outstanding_d;
    end
  end

  llpf_fifo #(
    .width (lpsz),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (recv_s),
    .wr_data_i (pf.lprq_page),
    .rd_en_i   (rd_s),
    .rd_data_o (head_s),
    .count_o   (count_s),
    .full_o    (full_s)
  );

endmodule
